// File: rtl/dm_responder_if.sv
// Data-memory port bundle: request and response valid/ready channels between the
// memory-access stage (master) and the responder (slave).
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states, internal RAM.
// Define DM_WRITE_LOG_EN to print a log line for every committed store.
module dm_responder #(
    parameter int unsigned DEPTH   = 3072,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    dm_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [33:0] LIMIT = 34'(DEPTH) << 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        live_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem_q [DEPTH];

    logic        accept, do_access;
    logic        cur_we;
    logic [3:0]  cur_be;
    logic [31:0] cur_addr, cur_wdata;
    logic [32:0] diff;
    logic        err;
    logic [AW-1:0] idx;
    logic [31:0] rd_word, merged;

    assign bus.req_ready = (state_q == ST_IDLE) && live_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign accept        = bus.req_valid && bus.req_ready;

    // With zero latency the access happens on the accept edge, so decode straight from the bus.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = bus.req_we;
            cur_be    = bus.req_be;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end else begin
            cur_we    = we_q;
            cur_be    = be_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    // 33-bit difference: bit 32 flags an address below BASE without wrapping into range.
    always_comb begin
        diff    = {1'b0, cur_addr} - {1'b0, BASE};
        err     = (cur_addr[1:0] != 2'b00) || diff[32] || ({2'b00, diff[31:0]} >= LIMIT);
        idx     = diff[AW+1:2];
        rd_word = err ? 32'h0 : mem_q[idx];
        merged  = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (cur_be[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        do_access = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef DM_WRITE_LOG_EN
    logic [31:0] pc_q, cur_pc;
    assign cur_pc = (state_q == ST_IDLE) ? bus.req_pc : pc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= 32'h0;
        end else begin
            if (accept) pc_q <= bus.req_pc;
            if (do_access && cur_we && !err && (cur_be != 4'b0000)) begin
                $display("@%h: *%h <= %h", cur_pc, cur_addr, merged);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.req_pc;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            live_q      <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= 4'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            if (accept) begin
                we_q    <= bus.req_we;
                be_q    <= bus.req_be;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (do_access) begin
                rsp_err_q   <= err;
                rsp_rdata_q <= (err || cur_we) ? 32'h0 : rd_word;
                if (cur_we && !err) mem_q[idx] <= merged;
            end
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// Randomized bench for dm_responder against a word-array reference model.
module tb_dm_responder;
    localparam int unsigned DEPTH   = 3072;
    localparam int unsigned LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] model [DEPTH];

    dm_responder_if bus ();

    dm_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
    endtask

    function automatic logic model_err(input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        return (addr[1:0] != 2'b00) || (a < longint'(BASE)) ||
               (a >= longint'(BASE) + 4 * longint'(DEPTH));
    endfunction

    task automatic scramble_req();
        bus.req_we    = 1'($urandom);
        bus.req_be    = 4'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_pc    = $urandom;
    endtask

    // Full transaction; all driving and sampling happens on negedges.
    task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
        int          n;
        logic        e;
        logic [31:0] exp_rd, w, held;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check_eq("ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_be    = be;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_pc    = $urandom;
        e      = model_err(addr);
        exp_rd = 32'h0;
        if (!e) begin
            w = model[(addr - BASE) >> 2];
            if (we) begin
                for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
                model[(addr - BASE) >> 2] = w;
            end else begin
                exp_rd = w;
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check_eq("busy_ready", 32'(bus.req_ready), 32'd0);
                bus.req_valid = 1'b0;
                scramble_req();
            end
        end while (!bus.rsp_valid && n < 40);
        check_eq("latency", 32'(n), 32'(LATENCY + 1));
        held = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("hold_rdata", bus.rsp_rdata, held);
            check_eq("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        check_eq("rdata", bus.rsp_rdata, exp_rd);
        check_eq("err", 32'(bus.rsp_err), 32'(e));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_eq("post_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("post_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        scramble_req();
        model_clear();

        // Reset and first access
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_valid", 32'(bus.rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("init_ready", 32'(bus.req_ready), 32'd1);
        check_eq("init_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("init_rdata", bus.rsp_rdata, 32'h0);
        check_eq("init_err", 32'(bus.rsp_err), 32'd0);
        xact(1'b0, 4'hF, 32'h0, 32'h0, 0);

        // Full store, partial store, error accesses, stall in RESP
        xact(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0);
        xact(1'b0, 4'h0, 32'h10, 32'h0, 0);
        xact(1'b1, 4'b0001, 32'h10, 32'h0000_00AA, 1);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 0);
        check_eq("merge_model", model[4], 32'hDEAD_BEAA);
        xact(1'b0, 4'hF, 32'h12, 32'h0, 0);
        xact(1'b0, 4'hF, BASE + 4 * DEPTH, 32'h0, 0);
        xact(1'b1, 4'hF, 32'h11, 32'h1234_5678, 0);
        xact(1'b1, 4'hF, BASE + 4 * DEPTH, 32'h1234_5678, 0);
        xact(1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 5);
        xact(1'b1, 4'hF, BASE + 4 * (DEPTH - 1), 32'hCAFE_F00D, 0);
        xact(1'b0, 4'hF, BASE + 4 * (DEPTH - 1), 32'h0, 0);

        // Reset during WAIT of a store discards it and clears the array
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_be    = 4'hF;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h5555_AAAA;
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("abort_valid", 32'(bus.rsp_valid), 32'd0);
        end
        reset = 1'b1;
        model_clear();
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_idle", 32'(bus.rsp_valid), 32'd0);
        end
        xact(1'b0, 4'hF, 32'h20, 32'h0, 0);
        xact(1'b0, 4'hF, 32'h10, 32'h0, 0);

        // Randomized mix over a small window, the top of the array and bad addresses
        for (int t = 0; t < 150; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       a = BASE + 4 * $urandom_range(0, 15);
            else if (sel == 6) a = BASE + 4 * (DEPTH - 1 - $urandom_range(0, 3));
            else if (sel == 7) a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            else if (sel == 8) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
            else               a = 32'hFFFF_FFFC;
            xact(1'($urandom), 4'($urandom), a, $urandom, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
